// File: rtl/rv32_inst_encoder.sv
// rtl/rv32_inst_encoder.sv - RV32IM instruction encoder with a 2-entry output FIFO
module rv32_inst_encoder #(
   parameter int NR_INST   = 46,
   parameter int OPC_WIDTH = $clog2(NR_INST + 1),
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OPC_WIDTH-1:0] in_opc,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [31:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_inst,
   output logic                 out_err,
   output logic [OPC_WIDTH-1:0] out_opc,
   output logic [CNT_WIDTH-1:0] nr_enc,
   output logic [CNT_WIDTH-1:0] nr_err
);
   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS} fmt_e;

   typedef struct packed {
      logic [31:0]          inst;
      logic                 err;
      logic [OPC_WIDTH-1:0] opc;
   } entry_t;

   fmt_e        fmt;
   logic [6:0]  op;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic        known;
   logic        imm_ok;
   logic [31:0] enc;
   logic [31:0] inst;
   logic        err;
   int          opc_i;

   entry_t      mem [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;

   assign opc_i = int'(in_opc);

   // Format and major opcode by opc range
   always_comb begin
      fmt   = FMT_R;
      op    = 7'h33;
      known = 1'b1;
      if (opc_i >= 1 && opc_i <= 10) begin
         fmt = FMT_R;
         op  = 7'h33;
      end else if (opc_i >= 11 && opc_i <= 19) begin
         fmt = (opc_i >= 15 && opc_i <= 17) ? FMT_SH : FMT_I;
         op  = 7'h13;
      end else if (opc_i >= 20 && opc_i <= 24) begin
         fmt = FMT_I;
         op  = 7'h03;
      end else if (opc_i >= 25 && opc_i <= 27) begin
         fmt = FMT_S;
         op  = 7'h23;
      end else if (opc_i >= 28 && opc_i <= 33) begin
         fmt = FMT_B;
         op  = 7'h63;
      end else if (opc_i == 34) begin
         fmt = FMT_J;
         op  = 7'h6F;
      end else if (opc_i == 35) begin
         fmt = FMT_I;
         op  = 7'h67;
      end else if (opc_i == 36 || opc_i == 37) begin
         fmt = FMT_U;
         op  = (opc_i == 36) ? 7'h37 : 7'h17;
      end else if (opc_i == 38) begin
         fmt = FMT_SYS;
         op  = 7'h73;
      end else if (opc_i >= 39 && opc_i <= NR_INST) begin
         fmt = FMT_R;
         op  = 7'h33;
      end else begin
         known = 1'b0;
      end
   end

   always_comb begin
      f3 = 3'd0;
      case (opc_i)
         6, 15, 21, 26, 29, 40:         f3 = 3'd1;
         9, 18, 22, 27, 41:             f3 = 3'd2;
         10, 19, 42:                    f3 = 3'd3;
         3, 12, 23, 30, 43:             f3 = 3'd4;
         7, 8, 16, 17, 24, 31, 44:      f3 = 3'd5;
         4, 13, 32, 45:                 f3 = 3'd6;
         5, 14, 33, 46:                 f3 = 3'd7;
         default:                       f3 = 3'd0;
      endcase
      f7 = 7'h00;
      if (opc_i == 2 || opc_i == 8 || opc_i == 17) f7 = 7'h20;
      else if (opc_i >= 39 && opc_i <= 46)         f7 = 7'h01;
   end

   always_comb begin
      case (fmt)
         FMT_I, FMT_S: imm_ok = (in_imm[31:11] == {21{in_imm[11]}});
         FMT_SH:       imm_ok = (in_imm[31:5] == 27'd0);
         FMT_B:        imm_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
         FMT_J:        imm_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
         FMT_U:        imm_ok = (in_imm[11:0] == 12'd0);
         FMT_SYS:      imm_ok = (in_imm[31:1] == 31'd0);
         default:      imm_ok = 1'b1;
      endcase
   end

   always_comb begin
      case (fmt)
         FMT_I:   enc = {in_imm[11:0], in_rs1, f3, in_rd, op};
         FMT_SH:  enc = {f7, in_imm[4:0], in_rs1, f3, in_rd, op};
         FMT_S:   enc = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], op};
         FMT_B:   enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], op};
         FMT_U:   enc = {in_imm[31:12], in_rd, op};
         FMT_J:   enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op};
         FMT_SYS: enc = {11'd0, in_imm[0], 13'd0, op};
         default: enc = {f7, in_rs2, in_rs1, f3, in_rd, op};
      endcase
   end

   assign err  = !(known && imm_ok);
   assign inst = err ? 32'd0 : enc;

   assign in_ready  = (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_inst  = mem[rd_ptr].inst;
   assign out_err   = mem[rd_ptr].err;
   assign out_opc   = mem[rd_ptr].opc;

   // Storage is cleared on reset so the idle head presents all zeros
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
         nr_enc <= '0;
         nr_err <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{inst: inst, err: err, opc: in_opc};
            wr_ptr      <= ~wr_ptr;
            if (err) nr_err <= nr_err + 1'b1;
            else     nr_enc <= nr_enc + 1'b1;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_rv32_inst_encoder.sv
// tb/tb_rv32_inst_encoder.sv - self-checking bench for rv32_inst_encoder
`timescale 1ns/1ps
module tb_rv32_inst_encoder;
   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_opc = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_inst;
   logic        out_err;
   logic [5:0]  out_opc;
   logic [31:0] nr_enc, nr_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] inst;
      bit          err;
      logic [5:0]  opc;
   } exp_t;

   exp_t q[$];
   int   m_enc = 0;
   int   m_err = 0;

   int r_f3  [10] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3};
   int i_f3  [9]  = '{0, 4, 6, 7, 1, 5, 5, 2, 3};
   int ld_f3 [5]  = '{0, 1, 2, 4, 5};
   int st_f3 [3]  = '{0, 1, 2};
   int br_f3 [6]  = '{0, 1, 4, 5, 6, 7};

   rv32_inst_encoder dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_err(out_err), .out_opc(out_opc), .nr_enc(nr_enc), .nr_err(nr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference encoder: mnemonic class tables, numeric ranges and shift/mask field placement
   function automatic void model(input int opc, input int rd, input int rs1, input int rs2,
                                 input logic [31:0] imm, output logic [31:0] inst, output bit err);
      longint      s;
      logic [31:0] o, f3, f7, base;
      string       fm;
      s = longint'($signed(imm));
      fm = "X"; o = 0; f3 = 0; f7 = 0;
      if (opc >= 1 && opc <= 10) begin
         fm = "R"; o = 'h33; f3 = r_f3[opc-1];
         if (opc == 2 || opc == 8) f7 = 'h20;
      end else if (opc >= 11 && opc <= 19) begin
         o = 'h13; f3 = i_f3[opc-11];
         fm = (opc >= 15 && opc <= 17) ? "H" : "I";
         if (opc == 17) f7 = 'h20;
      end else if (opc >= 20 && opc <= 24) begin
         fm = "I"; o = 'h03; f3 = ld_f3[opc-20];
      end else if (opc >= 25 && opc <= 27) begin
         fm = "S"; o = 'h23; f3 = st_f3[opc-25];
      end else if (opc >= 28 && opc <= 33) begin
         fm = "B"; o = 'h63; f3 = br_f3[opc-28];
      end else if (opc == 34) begin
         fm = "J"; o = 'h6F;
      end else if (opc == 35) begin
         fm = "I"; o = 'h67;
      end else if (opc == 36) begin
         fm = "U"; o = 'h37;
      end else if (opc == 37) begin
         fm = "U"; o = 'h17;
      end else if (opc == 38) begin
         fm = "E";
      end else if (opc >= 39 && opc <= 46) begin
         fm = "R"; o = 'h33; f3 = opc - 39; f7 = 'h01;
      end
      base = (32'(rs1) << 15) | (f3 << 12) | (32'(rd) << 7) | o;
      err = 1'b0; inst = 0;
      case (fm)
         "R": inst = (f7 << 25) | (32'(rs2) << 20) | base;
         "I": if (s < -2048 || s > 2047) err = 1; else inst = ((imm & 'hFFF) << 20) | base;
         "H": if (s < 0 || s > 31) err = 1; else inst = (f7 << 25) | (imm << 20) | base;
         "S": if (s < -2048 || s > 2047) err = 1;
              else inst = (((imm >> 5) & 'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
                          (f3 << 12) | ((imm & 'h1F) << 7) | o;
         "B": if (s < -4096 || s > 4094 || s % 2 != 0) err = 1;
              else inst = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) |
                          (32'(rs2) << 20) | (32'(rs1) << 15) | (f3 << 12) |
                          (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | o;
         "U": if ((imm & 'hFFF) != 0) err = 1; else inst = (imm & 'hFFFFF000) | (32'(rd) << 7) | o;
         "J": if (s < -1048576 || s > 1048574 || s % 2 != 0) err = 1;
              else inst = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) |
                          (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12) |
                          (32'(rd) << 7) | o;
         "E": if (s == 0) inst = 'h73; else if (s == 1) inst = 'h00100073; else err = 1;
         default: err = 1;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rstn) begin
         exp_t e;
         chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
         chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("nr_enc", nr_enc, m_enc);
         chk("nr_err", nr_err, m_err);
         if (out_valid && q.size() > 0) begin
            chk("out_inst", out_inst, q[0].inst);
            chk("out_err", 32'(out_err), 32'(q[0].err));
            chk("out_opc", 32'(out_opc), 32'(q[0].opc));
            if (out_ready) void'(q.pop_front());
         end
         if (in_valid && in_ready) begin
            model(int'(in_opc), int'(in_rd), int'(in_rs1), int'(in_rs2), in_imm, e.inst, e.err);
            e.opc = in_opc;
            q.push_back(e);
            if (e.err) m_err++;
            else       m_enc++;
         end
      end
   end

   task automatic send(input int opc, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
      int n = 0;
      in_opc = 6'(opc); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      chk("drain", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] mi;
      bit          me;
      model(11, 1, 0, 0, 5, mi, me);               chk("pin_addi", mi, 32'h00500093);
      model(2, 3, 1, 2, 0, mi, me);                chk("pin_sub", mi, 32'h402081B3);
      model(28, 0, 1, 2, -4, mi, me);              chk("pin_beq", mi, 32'hFE208EE3);
      model(38, 0, 0, 0, 1, mi, me);               chk("pin_ebreak", mi, 32'h00100073);
      model(36, 5, 0, 0, 32'h12345000, mi, me);    chk("pin_lui", mi, 32'h123452B7);
      model(34, 1, 0, 0, 8, mi, me);               chk("pin_jal", mi, 32'h008000EF);
      model(39, 3, 1, 2, 0, mi, me);               chk("pin_mul", mi, 32'h022081B3);
      model(11, 1, 0, 0, 2048, mi, me);            chk("pin_addi_err", 32'(me), 32'd1);

      #1 rstn = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_inst", out_inst, 0);
      chk("rst_out_opc", 32'(out_opc), 0);
      chk("rst_nr_enc", nr_enc, 0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      send(11, 1, 0, 0, 5);
      chk("addi_latency_valid", 32'(out_valid), 1);
      chk("addi_latency_inst", out_inst, 32'h00500093);
      chk("addi_nr_enc", nr_enc, 1);

      send(2, 3, 1, 2, 0);
      send(28, 0, 1, 2, -4);
      send(38, 0, 0, 0, 1);
      send(38, 0, 0, 0, 0);
      send(38, 0, 0, 0, 2);
      send(11, 1, 0, 0, 2048);
      send(28, 0, 1, 2, 3);
      send(0, 1, 2, 3, 0);
      send(47, 1, 2, 3, 0);
      drain();
      chk("err_nr_enc", nr_enc, 5);
      chk("err_nr_err", nr_err, 5);

      send(22, 7, 2, 0, -8);
      send(27, 0, 2, 7, 2047);
      send(17, 4, 4, 0, 31);
      send(37, 6, 0, 0, 32'hFFFFF000);
      send(34, 1, 0, 0, -1048576);
      send(35, 0, 1, 0, -2048);
      send(33, 0, 3, 4, 4094);
      send(46, 9, 10, 11, 0);
      send(15, 1, 1, 0, 32);
      send(36, 1, 0, 0, 32'h800);
      send(34, 1, 0, 0, 1048575);
      send(28, 0, 0, 0, -4098);
      drain();

      out_ready = 1'b0;
      send(11, 1, 0, 0, 1);
      send(11, 1, 0, 0, 2);
      fork
         send(11, 1, 0, 0, 3);
         begin
            repeat (3) @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_head_held", out_inst, 32'h00100093);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      out_ready = 1'b0;
      send(11, 2, 0, 0, 7);
      send(11, 3, 0, 0, 8);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_in_ready", 32'(in_ready), 1);
      chk("mid_rst_out_inst", out_inst, 0);
      chk("mid_rst_nr_enc", nr_enc, 0);
      chk("mid_rst_nr_err", nr_err, 0);
      q.delete();
      m_enc = 0;
      m_err = 0;
      @(posedge clk);
      #1 rstn = 1'b1;
      out_ready = 1'b1;
      send(13, 5, 6, 0, -1);
      chk("post_rst_inst", out_inst, 32'hFFF36293);
      chk("post_rst_nr_enc", nr_enc, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rv32_inst_encoder.md
Name: rv32_inst_encoder

Overview:
- Inverse of the RV32IM instruction decode unit: takes an opcode index (opc) plus register fields and an immediate, and produces the 32-bit RV32IM instruction word.
- Used by the program loader and the self-check stimulus generator to write instruction memory.
- Input and output use valid/ready handshakes, with a 2-entry output FIFO for backpressure.
- Flags illegal opc values and out-of-range immediates; keeps encode and error counters.

Parameters:
- NR_INST, 46, number of legal opc codes.
- OPC_WIDTH, $clog2(NR_INST+1) = 6, opc field width.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_opc  in  OPC_WIDTH  opc code; 1..46, 0 is illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  immediate, two's complement, byte offset for branches and jumps.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_inst  out  32  encoded instruction.
- out_err  out  1  request was illegal; out_inst is 0x00000000.
- out_opc  out  OPC_WIDTH  opc echoed with the word.
- nr_enc  out  CNT_WIDTH  count of words accepted without error.
- nr_err  out  CNT_WIDTH  count of error words accepted.

Behaviour:
- opc numbering, 1-based in this fixed order:
  - add sub xor or and sll srl sra slt sltu (1-10)
  - addi xori ori andi slli srli srai slti sltiu (11-19)
  - lb lh lw lbu lhu (20-24)
  - sb sh sw (25-27)
  - beq bne blt bge bltu bgeu (28-33)
  - jal jalr lui auipc (34-37)
  - ecall/ebreak (38)
  - mul mulh mulhsu mulhu div divu rem remu (39-46)
- Field placement follows RV32 R/I/S/B/U/J formats. funct7 is 0x00, 0x20 (sub, sra, srai) or 0x01 (M extension). Fields unused by a format are written as 0.
- Immediate legality:
  - I/S: -2048..2047.
  - slli/srli/srai: 0..31, with shamt in bits 24:20.
  - B: -4096..4094 and even.
  - J: -1048576..1048574 and even.
  - U: in_imm[11:0] must be 0; bits 31:12 are taken verbatim.
  - opc 38: in_imm 0 gives ecall (0x00000073), in_imm 1 gives ebreak (0x00100073); any other value is an error.
- Any violation, or opc of 0 or greater than NR_INST, gives out_err=1, out_inst=0, and out_opc echoes the request.
- Encoding is combinational on the request and written into the FIFO on accept (in_valid && in_ready).
- Latency: a word accepted in cycle N appears on out_* in cycle N+1 if the FIFO was empty.
- FIFO behaviour:
  - 2 entries with an occupancy count of 0..2.
  - in_ready = (count < 2); it does not depend combinationally on out_ready.
  - out_valid = (count > 0); out_* presents the head entry.
  - A pop occurs on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged and preserve order.
  - At count=2 no push occurs even if a pop happens that cycle; in_ready rises the following cycle.
  - The head entry is held stable while out_valid && !out_ready.
- Counters increment on accept, not on pop: nr_enc when the entry has no error, nr_err when it does. Both wrap modulo 2^CNT_WIDTH.
- Reset (asynchronous, effective at any time, including mid-stream):
  - count=0, out_valid=0, in_ready=1.
  - out_inst=0, out_err=0, out_opc=0, nr_enc=0, nr_err=0.
  - FIFO contents are discarded.
  - First accept is possible on the first clk edge after rstn deasserts.

Test Plan:
- addi x1,x0,5 (opc 11, rd=1, rs1=0, imm=5), out_ready=1 -> out_inst=0x00500093 one cycle later, out_err=0, nr_enc=1.
- sub x3,x1,x2 (opc 2), then beq x1,x2,-4 (opc 28) -> 0x402081B3 then 0xFE208EE3 on consecutive cycles.
- opc 38 with imm 1, then imm 0 -> 0x00100073 then 0x00000073. opc 38 with imm 2 -> out_err=1, out_inst=0, nr_err=1.
- Error cases, each giving out_err=1 and out_inst=0, with nr_err counting 4 and nr_enc unchanged:
  - addi with imm=2048
  - beq with imm=3
  - opc 0
  - opc 47
- Backpressure: out_ready=0 and three back-to-back requests (addi imm 1, 2, 3) -> in_ready=0 after two accepts and the third is held. Raise out_ready -> words emitted in order 0x00100093, 0x00200093, 0x00300093 with no loss or duplication.
- Assert rstn=0 while count=2 -> out_valid=0, in_ready=1 and counters 0 immediately, without waiting for clk. After release, the next request encodes normally.
